// File: rtl/tracking_pkg.sv
// Shared constants, FSM state type and channel helpers for the colour-tracking datapath.
package tracking_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam logic [31:0] NOT_FOUND    = 32'hFFFF_FFFF;

    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8:1];
    endfunction

    function automatic logic [31:0] blend(input logic [31:0] a, input logic [31:0] b);
        return {8'h00,
                avg8(a[R_LSB +: 8], b[R_LSB +: 8]),
                avg8(a[G_LSB +: 8], b[G_LSB +: 8]),
                avg8(a[B_LSB +: 8], b[B_LSB +: 8])};
    endfunction

endpackage

// File: rtl/marker_hit.sv
// Crosshair geometry: flags a pixel lying on either arm of a marker centred at (cx,cy).
module marker_hit #(
    parameter int unsigned ARM = 8
) (
    input  logic [31:0] col,
    input  logic [31:0] row,
    input  logic [31:0] cx,
    input  logic [31:0] cy,
    output logic        hit
);

    localparam logic signed [32:0] ARM_S = 33'(ARM);

    logic signed [32:0] dc;
    logic signed [32:0] dr;

    // Signed 33-bit differences keep arms from wrapping past the frame edges.
    assign dc = $signed({1'b0, col}) - $signed({1'b0, cx});
    assign dr = $signed({1'b0, row}) - $signed({1'b0, cy});

    assign hit = ((col == cx) && (dr <= ARM_S) && (dr >= -ARM_S)) ||
                 ((row == cy) && (dc <= ARM_S) && (dc >= -ARM_S));

endmodule

// File: rtl/marker_overlay.sv
// Stamps a crosshair at the tracked centroid onto a streamed frame (latency 1, full throughput).
// Define MARKER_BLEND_EN to average marker colour with the pixel instead of replacing it.
module marker_overlay
    import tracking_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned ARM        = 8,
    parameter logic [31:0] MARK_COLOR = 32'h00FF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] x_pos,
    input  logic [31:0] y_pos,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_sof,
    output logic        m_eol,
    output logic        sync_err
);

    state_t      state, state_n;
    logic [31:0] col, row, col_n, row_n;
    logic [31:0] cx, cy;
    logic        mark_en;
    logic        accept, pos_ok, err_n;
    logic [31:0] pcol, prow, pcx, pcy;
    logic        pen, geom_hit, hit;
    logic [31:0] out_data;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign pos_ok  = (x_pos != NOT_FOUND) && (y_pos != NOT_FOUND) &&
                     (x_pos < H_ACTIVE) && (y_pos < V_ACTIVE);

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_SOF;
        else       state <= state_n;
    end

    // An s_sof pixel is (0,0) of a new frame and is judged against the freshly presented position.
    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        err_n   = 1'b0;
        pcol    = col;
        prow    = row;
        pcx     = cx;
        pcy     = cy;
        pen     = 1'b0;
        if (s_sof) begin
            pcol = '0;
            prow = '0;
            pcx  = x_pos;
            pcy  = y_pos;
            pen  = pos_ok;
        end else if (state == ACTIVE && row < V_ACTIVE) begin
            pen = mark_en;
        end
        if (accept && (s_sof || state == ACTIVE)) begin
            state_n = ACTIVE;
            if (!s_sof && row == V_ACTIVE) begin
                err_n   = 1'b1;
                state_n = WAIT_SOF;
                col_n   = '0;
                row_n   = '0;
            end else if (s_eol || pcol == H_ACTIVE - 1) begin
                err_n = s_eol != (pcol == H_ACTIVE - 1);
                col_n = '0;
                row_n = prow + 1;
            end else begin
                col_n = pcol + 1;
                row_n = prow;
            end
        end
    end

    marker_hit #(.ARM(ARM)) u_hit (
        .col (pcol),
        .row (prow),
        .cx  (pcx),
        .cy  (pcy),
        .hit (geom_hit)
    );

    always_comb begin
        hit      = pen && geom_hit;
        out_data = s_data;
        if (hit) begin
`ifdef MARKER_BLEND_EN
            out_data = blend(s_data, MARK_COLOR);
`else
            out_data = MARK_COLOR;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col      <= '0;
            row      <= '0;
            cx       <= '0;
            cy       <= '0;
            mark_en  <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_sof    <= 1'b0;
            m_eol    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            col      <= col_n;
            row      <= row_n;
            sync_err <= err_n;
            if (accept && s_sof) begin
                cx      <= x_pos;
                cy      <= y_pos;
                mark_en <= pos_ok;
            end
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= out_data;
                m_sof   <= s_sof;
                m_eol   <= s_eol;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
